// File: rtl/fifo_packer_if.sv
// Handshake bundle between an upstream show-ahead FIFO, the packer and its downstream consumer.
// The slave modport is the packer side; master is the side that drives the FIFO/consumer inputs.
interface fifo_packer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PACK  = 4
);
  logic [WIDTH-1:0]      in_data;
  logic                  in_valid;
  logic                  in_ren;
  logic                  flush;
  logic [WIDTH*PACK-1:0] out_data;
  logic [PACK-1:0]       out_keep;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ren, out_data, out_keep, out_last, out_valid
  );

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ren, out_data, out_keep, out_last, out_valid
  );
endinterface

// File: rtl/fifo_packer.sv
// Packs PACK words popped from a show-ahead FIFO into one wide beat; flush closes a partial beat.
// Two states: StFill accumulates words, StHold presents the beat until downstream accepts it.
module fifo_packer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PACK  = 4
) (
  input logic          clk,
  input logic          rst,
  fifo_packer_if.slave bus
);
  localparam int unsigned IdxW = $clog2(PACK) + 1;

  typedef enum logic {StFill, StHold} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [WIDTH*PACK-1:0] data_q, data_d;
  logic [PACK-1:0]       keep_q, keep_d;
  logic                  last_q, last_d;
  logic                  pop;
  logic                  last_slot;

  assign pop       = bus.in_valid && (state_q == StFill);
  assign last_slot = (idx_q == IdxW'(PACK - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    unique case (state_q)
      StFill: begin
        if (pop) begin
          for (int i = 0; i < PACK; i++) begin
            if (idx_q == IdxW'(i)) begin
              data_d[i*WIDTH +: WIDTH] = bus.in_data;
              keep_d[i]                = 1'b1;
            end
          end
          idx_d = idx_q + IdxW'(1);
        end
        if (pop && last_slot) begin
          state_d = StHold;
          last_d  = bus.flush;
        end else if (bus.flush && (pop || (idx_q != '0))) begin
          // A flush with nothing buffered and nothing arriving is simply dropped.
          state_d = StHold;
          last_d  = 1'b1;
        end
      end
      StHold: begin
        if (bus.flush) begin
          last_d = 1'b1;
        end
        if (bus.out_ready) begin
          state_d = StFill;
          idx_d   = '0;
          data_d  = '0;
          keep_d  = '0;
          last_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFill;
      idx_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign bus.in_ren    = pop;
  assign bus.out_valid = (state_q == StHold);
  assign bus.out_data  = data_q;
  assign bus.out_keep  = keep_q;
  // A flush seen while holding must mark the beat even if it is accepted on that same edge.
  assign bus.out_last  = last_q || ((state_q == StHold) && bus.flush);
endmodule

// File: tb/tb_fifo_packer.sv
// Directed and randomized checks of fifo_packer with WIDTH=8, PACK=4.
module tb_fifo_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  fifo_packer_if #(.WIDTH(8), .PACK(4)) bus ();

  fifo_packer #(.WIDTH(8), .PACK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [31:0] data, input logic [3:0] keep,
                            input logic last);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_data"}, 64'(bus.out_data), 64'(data));
    check({tag, "_keep"}, 64'(bus.out_keep), 64'(keep));
    check({tag, "_last"}, 64'(bus.out_last), 64'(last));
  endtask

  // Pops one word per cycle; the last word optionally carries a flush.
  task automatic push4(input logic [31:0] words, input logic flush_last);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = words[i*8 +: 8];
      bus.flush    = flush_last && (i == 3);
      #1;
      check("pop_ren", 64'(bus.in_ren), 64'd1);
      step();
    end
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    #1;
  endtask

  task automatic sb_sample();
    logic [7:0] exp;
    if (bus.in_ren) begin
      check("ren_implies_valid", 64'(bus.in_valid), 64'd1);
      sb_q.push_back(bus.in_data);
    end
    if (bus.out_valid && bus.out_ready) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.out_keep[i]) begin
          if (sb_q.size() == 0) begin
            check("sb_underflow", 64'd0, 64'd1);
          end else begin
            exp = sb_q.pop_front();
            check("sb_word", 64'(bus.out_data[i*8 +: 8]), 64'(exp));
          end
        end else begin
          check("sb_pad_zero", 64'(bus.out_data[i*8 +: 8]), 64'd0);
        end
      end
    end
  endtask

  task automatic rnd_cycle(input logic iv, input logic fl, input logic ordy);
    bus.in_valid  = iv;
    bus.in_data   = 8'($urandom);
    bus.flush     = fl;
    bus.out_ready = ordy;
    #1;
    sb_sample();
    step();
  endtask

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    step();
    step();
    rst = 1'b0;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_keep", 64'(bus.out_keep), 64'd0);
    check("rst_data", 64'(bus.out_data), 64'd0);
    check("rst_last", 64'(bus.out_last), 64'd0);
    check("rst_ren", 64'(bus.in_ren), 64'd0);

    // Full beat, accepted immediately
    push4(32'h44332211, 1'b0);
    check_beat("full", 32'h44332211, 4'b1111, 1'b0);
    step();
    check("full_after_valid", 64'(bus.out_valid), 64'd0);

    // Partial beat closed by flush with no word arriving
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA1;
    step();
    bus.in_data  = 8'hA2;
    step();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    step();
    bus.flush    = 1'b0;
    #1;
    check_beat("partial", 32'h0000A2A1, 4'b0011, 1'b1);
    step();
    check("partial_after_valid", 64'(bus.out_valid), 64'd0);

    // Backpressure for 5 cycles with the FIFO still offering data
    bus.out_ready = 1'b0;
    push4(32'h04030201, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ren", 64'(bus.in_ren), 64'd0);
      check_beat("bp_hold", 32'h04030201, 4'b1111, 1'b0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("bp_release_valid", 64'(bus.out_valid), 64'd0);
    push4(32'h88776655, 1'b0);
    check_beat("bp_second", 32'h88776655, 4'b1111, 1'b0);
    step();

    // Idle flush is dropped
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    #1;
    check("idle_flush_valid", 64'(bus.out_valid), 64'd0);
    step();
    check("idle_flush_valid2", 64'(bus.out_valid), 64'd0);

    // Flush coinciding with the 4th pop
    push4(32'hC4C3C2C1, 1'b1);
    check_beat("flush4", 32'hC4C3C2C1, 4'b1111, 1'b1);
    step();

    // Flush arriving while the beat is held
    bus.out_ready = 1'b0;
    push4(32'hD4D3D2D1, 1'b0);
    check("hold_last_before", 64'(bus.out_last), 64'd0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    #1;
    check_beat("hold_flush", 32'hD4D3D2D1, 4'b1111, 1'b1);
    bus.out_ready = 1'b1;
    step();

    // Reset in the middle of HOLD discards the beat
    bus.out_ready = 1'b0;
    push4(32'h0F0E0D0C, 1'b0);
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_keep", 64'(bus.out_keep), 64'd0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hE1;
    bus.flush     = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    #1;
    check_beat("post_rst", 32'h000000E1, 4'b0001, 1'b1);
    step();

    // Randomized traffic against a scoreboard, then drain
    for (int c = 0; c < 10000; c++) begin
      rnd_cycle(($urandom_range(3) != 0), ($urandom_range(15) == 0), 1'($urandom_range(1)));
    end
    rnd_cycle(1'b0, 1'b0, 1'b1);
    rnd_cycle(1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      rnd_cycle(1'b0, 1'b0, 1'b1);
    end
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("sb_end_valid", 64'(bus.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
